// File: rtl/mult_div_unit.sv
// Iterative MIPS-style multiply/divide unit: one bit per cycle, HI/LO result registers.
// Define MDU_SIGNED_EN to enable signed MULT/DIV; otherwise Op[0] is ignored and all ops are unsigned.
module mult_div_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  Start,
  input  logic [1:0]            Op,
  input  logic [DATA_WIDTH-1:0] BusA,
  input  logic [DATA_WIDTH-1:0] BusB,
  input  logic                  HiWr,
  input  logic                  LoWr,
  output logic                  Busy,
  output logic                  Done,
  output logic [DATA_WIDTH-1:0] Hi,
  output logic [DATA_WIDTH-1:0] Lo
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = (W > 1) ? $clog2(W) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]    state;
  logic [CW-1:0] bitCnt;
  logic [W-1:0]  hiReg, loReg;
  logic [W-1:0]  accHi, accLo;   // mult: {partial product, multiplier}; div: {remainder, dividend->quotient}
  logic [W-1:0]  operand;        // multiplicand magnitude or divisor magnitude
  logic [W-1:0]  origA;
  logic          isDiv, divZero;

  // operand magnitudes at issue
  logic          signA, signB;
  logic [W-1:0]  magA, magB;

`ifdef MDU_SIGNED_EN
  logic negRes, negRem;

  always_comb begin
    signA = Op[0] & BusA[W-1];
    signB = Op[0] & BusB[W-1];
  end
`else
  logic unusedOp0;
  assign unusedOp0 = Op[0];

  always_comb begin
    signA = 1'b0;
    signB = 1'b0;
  end
`endif

  always_comb begin
    magA = signA ? (~BusA + 1'b1) : BusA;
    magB = signB ? (~BusB + 1'b1) : BusB;
  end

  // one iteration of shift-add multiply / restoring divide
  logic [W:0]   mulSum, divShift, divDiff;
  logic         divOk;
  logic [W-1:0] nextHi, nextLo;

  always_comb begin
    mulSum   = {1'b0, accHi} + (accLo[0] ? {1'b0, operand} : '0);
    divShift = {accHi, accLo[W-1]};
    divDiff  = divShift - {1'b0, operand};
    divOk    = ~divDiff[W];
    if (isDiv) begin
      nextHi = divOk ? divDiff[W-1:0] : divShift[W-1:0];
      nextLo = {accLo[W-2:0], divOk};
    end else begin
      nextHi = mulSum[W:1];
      nextLo = {mulSum[0], accLo[W-1:1]};
    end
  end

  // final result with sign correction and divide-by-zero override
  logic [2*W-1:0] prod;
  logic [W-1:0]   quo, rem;
  logic [W-1:0]   fixHi, fixLo;

  always_comb begin
    prod = {accHi, accLo};
    quo  = accLo;
    rem  = accHi;
`ifdef MDU_SIGNED_EN
    if (negRes) begin
      prod = ~prod + 1'b1;
      quo  = ~quo + 1'b1;
    end
    if (negRem) rem = ~rem + 1'b1;
`endif
    if (!isDiv) begin
      fixHi = prod[2*W-1:W];
      fixLo = prod[W-1:0];
    end else if (divZero) begin
      fixHi = origA;
      fixLo = '1;
    end else begin
      fixHi = rem;
      fixLo = quo;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state   <= IDLE;
      bitCnt  <= '0;
      hiReg   <= '0;
      loReg   <= '0;
      accHi   <= '0;
      accLo   <= '0;
      operand <= '0;
      origA   <= '0;
      isDiv   <= 1'b0;
      divZero <= 1'b0;
`ifdef MDU_SIGNED_EN
      negRes  <= 1'b0;
      negRem  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (Start) begin
            isDiv   <= Op[1];
            divZero <= (BusB == '0);
            origA   <= BusA;
            operand <= Op[1] ? magB : magA;
            accLo   <= Op[1] ? magA : magB;
            accHi   <= '0;
            bitCnt  <= '0;
`ifdef MDU_SIGNED_EN
            negRes  <= signA ^ signB;
            negRem  <= Op[1] & signA;
`endif
            state   <= CALC;
          end else begin
            if (HiWr) hiReg <= BusA;
            if (LoWr) loReg <= BusA;
          end
        end
        CALC: begin
          accHi  <= nextHi;
          accLo  <= nextLo;
          bitCnt <= bitCnt + 1'b1;
          if (bitCnt == CW'(W - 1)) state <= FIX;
        end
        FIX: begin
          hiReg <= fixHi;
          loReg <= fixLo;
          state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign Busy = (state == CALC) || (state == FIX);
  assign Done = (state == DONE);
  assign Hi   = hiReg;
  assign Lo   = loReg;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed corner cases plus random ops vs an arithmetic model.
module tb_mult_div_unit;
  localparam int W = 32;

  logic         Clk = 1'b0;
  logic         Reset, Start, HiWr, LoWr;
  logic [1:0]   Op;
  logic [W-1:0] BusA, BusB;
  logic         Busy, Done;
  logic [W-1:0] Hi, Lo;

  int tests = 0;
  int fails = 0;
  logic [W-1:0] expHi = '0, expLo = '0;

  mult_div_unit #(.DATA_WIDTH(W)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Op(Op), .BusA(BusA), .BusB(BusB),
    .HiWr(HiWr), .LoWr(LoWr), .Busy(Busy), .Done(Done), .Hi(Hi), .Lo(Lo)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // returns {HI, LO} from plain integer arithmetic
  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    bit     sgn;
    longint sa, sb, p, q, r;
`ifdef MDU_SIGNED_EN
    sgn = op[0];
`else
    sgn = 1'b0;
`endif
    sa = sgn ? longint'($signed(a)) : longint'({32'b0, a});
    sb = sgn ? longint'($signed(b)) : longint'({32'b0, b});
    if (!op[1]) begin
      p = sa * sb;
      return p;
    end
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  // issue an op; optionally re-pulse Start or MTHI/MTLO at CALC cycle k
  task automatic runOp(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int restartAt, input int mtAt, input string tag);
    logic [63:0] r;
    r = model(op, a, b);
    Op = op; BusA = a; BusB = b; Start = 1'b1;
    step();
    Start = 1'b0; HiWr = 1'b0; LoWr = 1'b0;
    chk({tag, ":busy"}, {63'd0, Busy}, 64'd1);
    for (int k = 1; k <= W; k++) begin
      if (k == restartAt) begin Start = 1'b1; Op = 2'b00; BusA = '1; BusB = '1; end
      if (k == mtAt) begin HiWr = 1'b1; LoWr = 1'b1; BusA = 32'h1234; end
      step();
      Start = 1'b0; HiWr = 1'b0; LoWr = 1'b0;
      chk({tag, ":hold"}, {Hi, Lo}, {expHi, expLo});
    end
    chk({tag, ":fixBusy"}, {62'd0, Busy, Done}, 64'd2);
    step();
    expHi = r[63:32];
    expLo = r[31:0];
    chk({tag, ":done"}, {63'd0, Done}, 64'd1);
    chk({tag, ":result"}, {Hi, Lo}, {expHi, expLo});
    step();
    chk({tag, ":idle"}, {62'd0, Busy, Done}, 64'd0);
  endtask

  logic [31:0] pool [4];

  initial begin
    logic [1:0]  rop;
    logic [31:0] ra, rb;
    pool[0] = 32'h0; pool[1] = 32'hFFFF_FFFF; pool[2] = 32'h8000_0000; pool[3] = 32'h1;

    Reset = 1'b1; Start = 1'b1; HiWr = 1'b1; LoWr = 1'b1; Op = 2'b00;
    BusA = 32'hDEAD_BEEF; BusB = 32'h5;
    step(); step();
    Reset = 1'b0; Start = 1'b0; HiWr = 1'b0; LoWr = 1'b0;
    chk("reset:hilo", {Hi, Lo}, 64'd0);
    chk("reset:busyDone", {62'd0, Busy, Done}, 64'd0);
    step();
    chk("reset:staysIdle", {62'd0, Busy, Done}, 64'd0);

    runOp(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, "multuMax");
    chk("multuMax:const", {Hi, Lo}, 64'hFFFF_FFFE_0000_0001);

    runOp(2'b01, 32'hFFFF_FFFD, 32'd7, 0, 0, "mult-3x7");
    runOp(2'b11, 32'hFFFF_FFF9, 32'd2, 0, 0, "div-7/2");
`ifdef MDU_SIGNED_EN
    chk("div-7/2:const", {Hi, Lo}, 64'hFFFF_FFFF_FFFF_FFFD);
`endif
    runOp(2'b10, 32'd100, 32'd0, 0, 0, "divu100/0");
    chk("divu100/0:const", {Hi, Lo}, {32'd100, 32'hFFFF_FFFF});
    runOp(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, "divMin/-1");
    runOp(2'b11, 32'hFFFF_FFF9, 32'd0, 0, 0, "div-7/0");

    runOp(2'b10, 32'd10, 32'd3, 5, 0, "divuRestart");
    chk("divuRestart:const", {Hi, Lo}, {32'd1, 32'd3});

    runOp(2'b00, 32'd6, 32'd9, 0, 3, "mthiDuringCalc");

    HiWr = 1'b1; LoWr = 1'b1; BusA = 32'hABCD;
    step();
    HiWr = 1'b0; LoWr = 1'b0;
    expHi = 32'hABCD; expLo = 32'hABCD;
    chk("mthiMtlo", {Hi, Lo}, 64'h0000_ABCD_0000_ABCD);
    HiWr = 1'b1; BusA = 32'h5555;
    step();
    HiWr = 1'b0;
    expHi = 32'h5555;
    chk("mthiOnly", {Hi, Lo}, {expHi, expLo});

    // Start wins over coincident MTHI/MTLO
    HiWr = 1'b1; LoWr = 1'b1;
    runOp(2'b00, 32'd12, 32'd11, 0, 0, "startVsMt");

    Op = 2'b00; BusA = '1; BusB = '1; Start = 1'b1;
    step();
    Start = 1'b0;
    repeat (9) step();
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    expHi = '0; expLo = '0;
    chk("abort:hilo", {Hi, Lo}, 64'd0);
    chk("abort:busyDone", {62'd0, Busy, Done}, 64'd0);
    for (int k = 0; k < W + 4; k++) begin
      step();
      chk("abort:noDone", {62'd0, Busy, Done}, 64'd0);
    end

    for (int i = 0; i < 20; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra = ($urandom_range(0, 2) == 0) ? pool[$urandom_range(0, 3)] : $urandom;
      rb = ($urandom_range(0, 2) == 0) ? pool[$urandom_range(0, 3)] : $urandom;
      if ($urandom_range(0, 3) == 0) rb = rb >> $urandom_range(8, 28);
      runOp(rop, ra, rb, 0, 0, "random");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
